hazard_ctrl: RTL and testbench

- Pipeline stall/flush controller for the 5-stage MIPS core (IF/ID/EX/MA/WB).
- Detects load-use hazards that operand forwarding cannot cover, and sequences the multi-cycle multiply/divide unit with a busy counter.
- Resolves taken-branch flushes, then drives PC/IF-ID hold, ID-EX bubble insertion and IF-ID flush.

---
 rtl/hazard_ctrl_if.sv | 48 ++++
 rtl/hazard_ctrl.sv | 104 ++++++++++
 tb/tb_hazard_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX hazard inputs in, stall/flush controls and mul/div status out.
// Latency: none; this is a plain signal grouping.
// Backpressure: none; the stall/flush outputs themselves throttle the pipeline.
// Ports: master = pipeline side (drives id_*/ex_*/branch_taken), slave = hazard_ctrl.
// Optional macro HAZ_PERF_CNT_EN adds perf_stall_cycles and perf_flushes.
interface hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       id_is_muldiv;
  logic       id_is_div;
  logic       id_reads_hilo;
  logic       ex_is_load;
  logic [4:0] ex_rt;
  logic       branch_taken;
  logic       pc_stall;
  logic       if_id_stall;
  logic       id_ex_bubble;
  logic       if_id_flush;
  logic       md_start;
  logic       md_busy;
  logic       md_done;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_muldiv, id_is_div,
           id_reads_hilo, ex_is_load, ex_rt, branch_taken,
    input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, md_start,
           md_busy, md_done
`ifdef HAZ_PERF_CNT_EN
    , input perf_stall_cycles, perf_flushes
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_muldiv, id_is_div,
           id_reads_hilo, ex_is_load, ex_rt, branch_taken,
    output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, md_start,
           md_busy, md_done
`ifdef HAZ_PERF_CNT_EN
    , output perf_stall_cycles, perf_flushes
`endif
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use and mul/div hazards, branch flush.
// Latency: stall/flush/md_start combinational same cycle; md_busy/md_done registered.
// Backpressure: asserts pc_stall/if_id_stall + ID/EX bubble; taken branch overrides stall with a flush.
// Ports: clk, rst (async active-high), bus (hazard_ctrl_if.slave).
// Optional macro HAZ_PERF_CNT_EN adds 32-bit stall-cycle and flush counters.
module hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             md_busy_q;
  logic             md_done_q;

  logic load_use;
  logic md_hazard;
  logic stall;
  logic md_start;

  // ex_rt==0 is excluded: a load to $zero creates no real dependency.
  assign load_use = bus.ex_is_load & (bus.ex_rt != 5'd0) &
                    ((bus.id_uses_rs & (bus.id_rs == bus.ex_rt)) |
                     (bus.id_uses_rt & (bus.id_rt == bus.ex_rt)));

  assign md_hazard = md_busy_q & (bus.id_is_muldiv | bus.id_reads_hilo);
  assign stall     = load_use | md_hazard;

  // While busy, any muldiv in ID stalls, so md_start can only fire from IDLE.
  assign md_start = bus.id_is_muldiv & ~stall & ~bus.branch_taken & ~rst;

  // Combinational controls are forced low during reset.
  assign bus.pc_stall     = ~rst & stall & ~bus.branch_taken;
  assign bus.if_id_stall  = ~rst & stall & ~bus.branch_taken;
  assign bus.id_ex_bubble = ~rst & (stall | bus.branch_taken);
  assign bus.if_id_flush  = ~rst & bus.branch_taken;
  assign bus.md_start     = md_start;
  assign bus.md_busy      = md_busy_q;
  assign bus.md_done      = md_done_q;

  // cnt is loaded with LAT-1 and counts to zero, giving exactly LAT busy
  // cycles; md_done lands in the first non-busy cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      md_busy_q <= 1'b0;
      md_done_q <= 1'b0;
    end else begin
      md_done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (md_start) begin
            state     <= BUSY;
            cnt       <= bus.id_is_div ? DIV_INIT : MUL_INIT;
            md_busy_q <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state     <= IDLE;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          md_busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall & ~bus.branch_taken) perf_stall_q <= perf_stall_q + 32'd1;
      if (bus.branch_taken)          perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed cycles push hand-computed output vectors, monitor compares.
// Latency: expected vectors are for the same cycle the inputs are applied.
// Backpressure: not applicable; the monitor checks every cycle that has a queued expectation.
module tb_hazard_ctrl;
  logic clk;
  logic rst;

  hazard_ctrl_if hif ();

  hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Vector order: {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, md_start, md_busy, md_done}
  typedef struct {
    logic [6:0] v;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [6:0] out_vec();
    return {hif.pc_stall, hif.if_id_stall, hif.id_ex_bubble, hif.if_id_flush,
            hif.md_start, hif.md_busy, hif.md_done};
  endfunction

  task automatic chk(input logic [6:0] act, input logic [6:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (ps,ifs,bub,fl,st,busy,done)", nm, act, exp);
    end
  endtask

  // Monitor: samples 2 time units after each negedge, after that cycle's stimulus settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(out_vec(), e.v, e.nm);
      end
    end
  end

  // Apply one cycle of inputs at the negedge and queue the expected outputs.
  task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                     input logic urt, input logic md, input logic dv, input logic hilo,
                     input logic ld, input logic [4:0] ert, input logic br,
                     input logic [6:0] v, input string nm);
    exp_t e;
    @(negedge clk);
    hif.id_rs         = rs;
    hif.id_rt         = rt;
    hif.id_uses_rs    = urs;
    hif.id_uses_rt    = urt;
    hif.id_is_muldiv  = md;
    hif.id_is_div     = dv;
    hif.id_reads_hilo = hilo;
    hif.ex_is_load    = ld;
    hif.ex_rt         = ert;
    hif.branch_taken  = br;
    e.v  = v;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [6:0] v, input string nm);
    cyc(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, v, nm);
  endtask

  localparam logic [6:0] Z    = 7'b000_0000;
  localparam logic [6:0] STL  = 7'b111_0000;
  localparam logic [6:0] STRT = 7'b000_0100;
  localparam logic [6:0] BSY  = 7'b000_0010;
  localparam logic [6:0] STB  = 7'b111_0010;
  localparam logic [6:0] DONE = 7'b000_0001;
  localparam logic [6:0] SD   = 7'b000_0101;
  localparam logic [6:0] FL   = 7'b001_1000;
  localparam logic [6:0] FLB  = 7'b001_1010;

  initial begin
    rst = 1'b1;
    hif.id_rs = '0; hif.id_rt = '0; hif.id_uses_rs = 0; hif.id_uses_rt = 0;
    hif.id_is_muldiv = 0; hif.id_is_div = 0; hif.id_reads_hilo = 0;
    hif.ex_is_load = 0; hif.ex_rt = '0; hif.branch_taken = 0;

    // Reset: every output low even with hazard-provoking inputs.
    cyc(5'd8, 5'd0, 1, 0, 1, 0, 0, 1, 5'd8, 1, Z, "reset_outputs_low");
    #4 rst = 1'b0;
    idle(Z, "after_reset_idle");

    // Load-use through rs, then clear.
    cyc(5'd8, 5'd0, 1, 0, 0, 0, 0, 1, 5'd8, 0, STL, "load_use_rs");
    idle(Z, "load_use_cleared");
    // Load-use through rt (store data).
    cyc(5'd0, 5'd9, 0, 1, 0, 0, 0, 1, 5'd9, 0, STL, "load_use_rt");
    // rt matches but is unused, rs used but different.
    cyc(5'd3, 5'd9, 1, 0, 0, 0, 0, 1, 5'd9, 0, Z, "rt_match_unused");
    // Register match but EX not a load.
    cyc(5'd8, 5'd8, 1, 1, 0, 0, 0, 0, 5'd8, 0, Z, "no_load_no_stall");
    // Load to $zero never stalls.
    cyc(5'd0, 5'd0, 1, 1, 0, 0, 0, 1, 5'd0, 0, Z, "ex_rt_zero");

    // mult then mfhi.
    cyc(5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 0, STRT, "mult_start");
    for (int i = 1; i <= 4; i++)
      cyc(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 5'd0, 0, STB, $sformatf("mfhi_stall_%0d", i));
    cyc(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 5'd0, 0, DONE, "mfhi_issue_at_done");
    idle(Z, "mult_idle");

    // Back-to-back div.
    cyc(5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 5'd0, 0, STRT, "div1_start");
    for (int i = 1; i <= 32; i++)
      cyc(5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 5'd0, 0, STB, $sformatf("div2_stall_%0d", i));
    cyc(5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 5'd0, 0, SD, "div2_start_with_done");
    for (int i = 34; i <= 65; i++)
      idle(BSY, $sformatf("div2_busy_%0d", i));
    idle(DONE, "div2_done");
    idle(Z, "div2_idle");

    // Branch beats load-use and muldiv issue.
    cyc(5'd8, 5'd0, 1, 0, 1, 0, 0, 1, 5'd8, 1, FL, "branch_over_stall");
    idle(Z, "branch_cleared");

    // Branch during a mult does not abort it.
    cyc(5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 0, STRT, "mult_b_start");
    cyc(5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 5'd0, 1, FLB, "branch_while_busy");
    for (int i = 2; i <= 4; i++)
      idle(BSY, $sformatf("mult_b_busy_%0d", i));
    idle(DONE, "mult_b_done");

    // Reset in busy cycle 10 of a div.
    cyc(5'd0, 5'd0, 0, 0, 1, 1, 0, 0, 5'd0, 0, STRT, "div_r_start");
    for (int i = 1; i <= 10; i++)
      idle(BSY, $sformatf("div_r_busy_%0d", i));
    #4 rst = 1'b1;
    #1 chk(out_vec(), Z, "async_reset_mid_div");
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++)
      idle(Z, $sformatf("no_done_after_reset_%0d", i));
    cyc(5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 5'd0, 0, STRT, "mult_after_reset");
    for (int i = 1; i <= 4; i++)
      idle(BSY, $sformatf("mult_r_busy_%0d", i));
    idle(DONE, "mult_r_done");
    idle(Z, "final_idle");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
